// File: rtl/mips_top_level_cpu.sv
// Multi-cycle MIPS-I subset CPU with a single Avalon-MM master for fetch and data.
// Sequence per instruction: FETCH -> EXEC -> (MEM) -> WB, with one branch delay slot.
module mips_top_level_cpu #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  typedef enum logic [2:0] {StFetch, StExec, StMem, StWb, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, npc_q, npc_d, tgt_q, tgt_d, ir_q, ir_d, res_q, res_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [4:0]  dst_q, dst_d;
  logic        read_q, read_d, write_q, write_d, active_q, active_d;
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, sh;
  logic [31:0] a, b, simm, zimm, brt, ea;

  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign sh    = ir_q[10:6];
  assign funct = ir_q[5:0];
  assign a     = regs_q[rs];
  assign b     = regs_q[rt];
  assign simm  = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zimm  = {16'h0, ir_q[15:0]};
  assign brt   = npc_q + {simm[29:0], 2'b00};
  assign ea    = a + simm;

  assign active      = active_q;
  assign register_v0 = regs_q[2];
  assign address     = addr_q;
  assign read        = read_q;
  assign write       = write_q;
  assign writedata   = wdata_q;
  assign byteenable  = 4'b1111;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    npc_d    = npc_q;
    tgt_d    = tgt_q;
    ir_d     = ir_q;
    res_d    = res_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    dst_d    = dst_q;
    read_d   = read_q;
    write_d  = write_q;
    active_d = active_q;
    regs_d   = regs_q;
    case (state_q)
      StFetch: begin
        if (read_q && !waitrequest) begin
          ir_d    = readdata;
          read_d  = 1'b0;
          state_d = StExec;
        end else begin
          read_d = 1'b1;
          addr_d = pc_q;
        end
      end
      StExec: begin
        res_d   = '0;
        dst_d   = '0;
        tgt_d   = npc_q + 32'd4;
        state_d = StWb;
        case (op)
          6'h00: begin
            dst_d = rd;
            case (funct)
              6'h00: res_d = b << sh;
              6'h02: res_d = b >> sh;
              6'h03: res_d = $signed(b) >>> sh;
              6'h04: res_d = b << a[4:0];
              6'h06: res_d = b >> a[4:0];
              6'h07: res_d = $signed(b) >>> a[4:0];
              6'h08: begin dst_d = '0; tgt_d = a; end
              6'h09: begin res_d = pc_q + 32'd8; tgt_d = a; end
              6'h21: res_d = a + b;
              6'h23: res_d = a - b;
              6'h24: res_d = a & b;
              6'h25: res_d = a | b;
              6'h26: res_d = a ^ b;
              6'h27: res_d = ~(a | b);
              6'h2a: res_d = {31'b0, $signed(a) < $signed(b)};
              6'h2b: res_d = {31'b0, a < b};
              default: dst_d = '0;
            endcase
          end
          6'h02: tgt_d = {npc_q[31:28], ir_q[25:0], 2'b00};
          6'h03: begin
            tgt_d = {npc_q[31:28], ir_q[25:0], 2'b00};
            dst_d = 5'd31;
            res_d = pc_q + 32'd8;
          end
          6'h04: if (a == b) tgt_d = brt;
          6'h05: if (a != b) tgt_d = brt;
          6'h09: begin dst_d = rt; res_d = a + simm; end
          6'h0a: begin dst_d = rt; res_d = {31'b0, $signed(a) < $signed(simm)}; end
          6'h0b: begin dst_d = rt; res_d = {31'b0, a < simm}; end
          6'h0c: begin dst_d = rt; res_d = a & zimm; end
          6'h0d: begin dst_d = rt; res_d = a | zimm; end
          6'h0e: begin dst_d = rt; res_d = a ^ zimm; end
          6'h0f: begin dst_d = rt; res_d = {ir_q[15:0], 16'h0}; end
          6'h23: begin
            dst_d   = rt;
            addr_d  = {ea[31:2], 2'b00};
            read_d  = 1'b1;
            state_d = StMem;
          end
          6'h2b: begin
            addr_d  = {ea[31:2], 2'b00};
            wdata_d = b;
            write_d = 1'b1;
            state_d = StMem;
          end
          default: ;
        endcase
      end
      StMem: begin
        if (!waitrequest) begin
          if (read_q) res_d = readdata;
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = StWb;
        end
      end
      StWb: begin
        if (dst_q != 5'd0) regs_d[dst_q] = res_q;
        pc_d  = npc_q;
        npc_d = tgt_q;
        // A zero fetch address is the halt condition; the fetch is never issued.
        if (npc_q == 32'h0) begin
          state_d  = StHalt;
          active_d = 1'b0;
        end else begin
          state_d = StFetch;
        end
      end
      StHalt: begin
        read_d   = 1'b0;
        write_d  = 1'b0;
        active_d = 1'b0;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StFetch;
      pc_q     <= RESET_VECTOR;
      npc_q    <= RESET_VECTOR + 32'd4;
      tgt_q    <= '0;
      ir_q     <= '0;
      res_q    <= '0;
      addr_q   <= RESET_VECTOR;
      wdata_q  <= '0;
      dst_q    <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      active_q <= 1'b1;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      npc_q    <= npc_d;
      tgt_q    <= tgt_d;
      ir_q     <= ir_d;
      res_q    <= res_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      dst_q    <= dst_d;
      read_q   <= read_d;
      write_q  <= write_d;
      active_q <= active_d;
      for (int i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
    end
  end

endmodule

// File: tb/tb_mips_top_level_cpu.sv
// Bench for mips_top_level_cpu: RAM with programmable wait states, an instruction-level
// model that predicts every bus transfer and the final $v0, and literal result pins.
module tb_mips_top_level_cpu;

  localparam logic [31:0] RV = 32'h0000_0004;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  logic        clk, reset, active, write, read, waitrequest;
  logic [31:0] register_v0, address, writedata, readdata;
  logic [3:0]  byteenable;

  logic [31:0] mem [256];
  logic [31:0] mm  [256];
  logic [31:0] prog [$];
  xfer_t       exp_q [$];
  logic [31:0] model_v0;
  int          n_checks = 0, n_err = 0;
  int          nwait = 0, wcnt = 0;

  mips_top_level_cpu #(.RESET_VECTOR(RV)) dut (
    .clk         (clk),
    .reset       (reset),
    .active      (active),
    .register_v0 (register_v0),
    .address     (address),
    .write       (write),
    .read        (read),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign readdata    = mem[address[9:2]];
  assign waitrequest = (read || write) && (wcnt < nwait);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] r_op(input logic [5:0] fn, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic p(input logic [31:0] w);
    prog.push_back(w);
  endtask

  task automatic load_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      mm[i]  = '0;
    end
    foreach (prog[i]) begin
      mem[i + 1] = prog[i];
      mm[i + 1]  = prog[i];
    end
  endtask

  // Instruction-set interpreter: one step per instruction, delay slot via pc/npc pair.
  task automatic model_build();
    logic [31:0] r [32];
    logic [31:0] pc, npc, nn, ir, x, y, si, zi, ea;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    int          steps;
    exp_q.delete();
    for (int i = 0; i < 32; i++) r[i] = '0;
    pc = RV;
    npc = RV + 32'd4;
    steps = 0;
    while (pc != 32'h0 && steps < 2000) begin
      exp_q.push_back('{wr: 1'b0, addr: pc, data: 32'h0});
      ir = mm[pc[9:2]];
      op = ir[31:26]; rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
      sh = ir[10:6];  fn = ir[5:0];
      x = r[rs]; y = r[rt];
      si = {{16{ir[15]}}, ir[15:0]};
      zi = {16'h0, ir[15:0]};
      ea = x + si;
      nn = npc + 32'd4;
      case (op)
        6'h00: case (fn)
          6'h00: r[rd] = y << sh;
          6'h02: r[rd] = y >> sh;
          6'h03: r[rd] = $signed(y) >>> sh;
          6'h04: r[rd] = y << x[4:0];
          6'h06: r[rd] = y >> x[4:0];
          6'h07: r[rd] = $signed(y) >>> x[4:0];
          6'h08: nn = x;
          6'h09: begin nn = x; r[rd] = pc + 32'd8; end
          6'h21: r[rd] = x + y;
          6'h23: r[rd] = x - y;
          6'h24: r[rd] = x & y;
          6'h25: r[rd] = x | y;
          6'h26: r[rd] = x ^ y;
          6'h27: r[rd] = ~(x | y);
          6'h2a: r[rd] = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
          6'h2b: r[rd] = (x < y) ? 32'd1 : 32'd0;
          default: ;
        endcase
        6'h02: nn = {npc[31:28], ir[25:0], 2'b00};
        6'h03: begin nn = {npc[31:28], ir[25:0], 2'b00}; r[31] = pc + 32'd8; end
        6'h04: if (x == y) nn = npc + (si << 2);
        6'h05: if (x != y) nn = npc + (si << 2);
        6'h09: r[rt] = x + si;
        6'h0a: r[rt] = ($signed(x) < $signed(si)) ? 32'd1 : 32'd0;
        6'h0b: r[rt] = (x < si) ? 32'd1 : 32'd0;
        6'h0c: r[rt] = x & zi;
        6'h0d: r[rt] = x | zi;
        6'h0e: r[rt] = x ^ zi;
        6'h0f: r[rt] = zi << 16;
        6'h23: begin
          exp_q.push_back('{wr: 1'b0, addr: {ea[31:2], 2'b00}, data: 32'h0});
          r[rt] = mm[ea[9:2]];
        end
        6'h2b: begin
          exp_q.push_back('{wr: 1'b1, addr: {ea[31:2], 2'b00}, data: y});
          mm[ea[9:2]] = y;
        end
        default: ;
      endcase
      r[0] = '0;
      pc = npc;
      npc = nn;
      steps++;
    end
    model_v0 = r[2];
  endtask

  // RAM responder and per-transfer compare against the model's expected bus stream.
  initial begin : bus
    logic        s_rst, s_req, s_wait, stall_prev, snap_rd, snap_wr;
    logic [31:0] snap_addr, snap_wd;
    xfer_t       e;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      s_rst  = reset;
      s_req  = read || write;
      s_wait = waitrequest;
      if (!s_rst && s_req) begin
        if (s_wait) begin
          if (stall_prev) begin
            check("stall_read", {31'b0, read}, {31'b0, snap_rd});
            check("stall_write", {31'b0, write}, {31'b0, snap_wr});
            check("stall_addr", address, snap_addr);
            check("stall_wdata", writedata, snap_wd);
          end
          stall_prev = 1'b1;
          snap_rd = read; snap_wr = write; snap_addr = address; snap_wd = writedata;
        end else begin
          stall_prev = 1'b0;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_xfer: got addr %h wr %b expected no transfer",
                     address, write);
          end else begin
            e = exp_q.pop_front();
            check("xfer_wr", {31'b0, write}, {31'b0, e.wr});
            check("xfer_addr", address, e.addr);
            check("xfer_be", {28'b0, byteenable}, 32'hF);
            if (e.wr) check("xfer_wdata", writedata, e.data);
          end
          if (write) mem[address[9:2]] = writedata;
        end
      end else begin
        stall_prev = 1'b0;
      end
      @(posedge clk);
      #1;
      if (s_rst || !s_req || !s_wait) wcnt = 0;
      else wcnt++;
    end
  end

  task automatic run_test(input string nm, input int w, input int reset_at,
                          input logic [31:0] lit_v0);
    int cyc;
    reset = 1'b1;
    nwait = w;
    load_mem();
    model_build();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check({nm, "_rst_active"}, {31'b0, active}, 32'h1);
    check({nm, "_rst_read"}, {31'b0, read}, 32'h0);
    check({nm, "_rst_write"}, {31'b0, write}, 32'h0);
    check({nm, "_rst_v0"}, register_v0, 32'h0);
    cyc = 0;
    while (active && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == reset_at) begin
        reset = 1'b1;
        load_mem();
        model_build();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check({nm, "_midrst_v0"}, register_v0, 32'h0);
        check({nm, "_midrst_active"}, {31'b0, active}, 32'h1);
        check({nm, "_midrst_read"}, {31'b0, read}, 32'h0);
      end
    end
    check({nm, "_halted"}, {31'b0, active}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check({nm, "_halt_bus"}, {30'b0, read, write}, 32'h0);
    check({nm, "_pending_xfers"}, exp_q.size(), 32'h0);
    check({nm, "_v0_model"}, register_v0, model_v0);
    check({nm, "_model_pin"}, model_v0, lit_v0);
    check({nm, "_v0_lit"}, register_v0, lit_v0);
  endtask

  task automatic slt_prog(input logic [5:0] fn, input logic [4:0] s, input logic [4:0] t);
    prog.delete();
    p(i_op(6'h09, 0, 3, 16'hFFF0));
    p(r_op(6'h00, 0, 3, 3, 16));
    p(i_op(6'h09, 0, 4, 16'hFFFF));
    p(r_op(6'h00, 0, 4, 4, 16));
    p(r_op(fn, s, t, 2, 0));
    p(r_op(6'h08, 0, 0, 0, 0));
    p(32'h0);
  endtask

  initial begin
    reset = 1'b1;

    slt_prog(6'h2a, 4, 3);
    run_test("slt_neg", 0, 0, 32'h0);
    slt_prog(6'h2a, 3, 4);
    run_test("slt_swap", 0, 0, 32'h1);
    slt_prog(6'h2b, 4, 3);
    run_test("sltu", 1, 0, 32'h0);

    prog.delete();
    p(i_op(6'h09, 0, 2, 16'h7FFF));
    p(32'hFC00_0000);
    p(i_op(6'h09, 2, 2, 16'h0001));
    p(r_op(6'h08, 0, 0, 0, 0));
    p(32'h0);
    run_test("addiu_carry", 0, 0, 32'h0000_8000);
    run_test("mid_reset", 1, 10, 32'h0000_8000);

    prog.delete();
    p(i_op(6'h0f, 0, 2, 16'hABCD));
    p(r_op(6'h08, 0, 0, 0, 0));
    p(32'h0);
    run_test("lui", 0, 0, 32'hABCD_0000);

    prog.delete();
    p(i_op(6'h0f, 0, 3, 16'hDEAD));
    p(i_op(6'h0d, 3, 3, 16'hBEEF));
    p(i_op(6'h2b, 0, 3, 16'h0040));
    p(i_op(6'h23, 0, 2, 16'h0040));
    p(r_op(6'h08, 0, 0, 0, 0));
    p(32'h0);
    run_test("sw_lw_wait", 3, 0, 32'hDEAD_BEEF);

    prog.delete();
    p(i_op(6'h09, 0, 5, 16'h0007));
    p(i_op(6'h04, 0, 0, 16'h0002));
    p(i_op(6'h09, 0, 2, 16'h0011));
    p(i_op(6'h09, 2, 2, 16'h0100));
    p(i_op(6'h09, 2, 2, 16'h0022));
    p(r_op(6'h08, 0, 0, 0, 0));
    p(32'h0);
    run_test("beq_slot", 0, 0, 32'h0000_0033);

    prog.delete();
    p(i_op(6'h09, 0, 3, 16'hFFF8));
    p({6'h03, 26'h8});
    p(r_op(6'h03, 0, 3, 2, 1));
    p(i_op(6'h09, 2, 2, 16'h0001));
    p(r_op(6'h08, 0, 0, 0, 0));
    p(32'h0);
    p(32'hFC00_0000);
    p(r_op(6'h02, 0, 3, 4, 28));
    p(i_op(6'h0e, 4, 4, 16'h00F0));
    p(r_op(6'h21, 2, 4, 2, 0));
    p(r_op(6'h08, 31, 0, 0, 0));
    p(r_op(6'h27, 0, 0, 5, 0));
    run_test("jal_shift", 2, 0, 32'h0000_00FC);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
